// File: rtl/mult_control_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mult_control_if : push-button levels in, datapath strobes out            |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface mult_control_if #(
  parameter int N_BITS = 8
);
  localparam int CNT_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;

  logic             Run;
  logic             ClearA_LoadB;
  logic             M;
  logic             Ld_B;
  logic             Clear_XA;
  logic             Ld_A;
  logic             Add;
  logic             Sub;
  logic             Shift_En;
  logic             Busy;
  logic             Done;
  logic [CNT_W-1:0] Count;

  // master = sequencer, slave = top level / datapath side
  modport master (
    input  Run, ClearA_LoadB, M,
    output Ld_B, Clear_XA, Ld_A, Add, Sub, Shift_En, Busy, Done, Count
  );

  modport slave (
    output Run, ClearA_LoadB, M,
    input  Ld_B, Clear_XA, Ld_A, Add, Sub, Shift_En, Busy, Done, Count
  );
endinterface
`default_nettype wire

// File: rtl/mult_control.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mult_control : add/shift sequencer for the 8-bit signed multiplier       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module mult_control #(
  parameter int N_BITS = 8
) (
  input  logic          Clk,
  input  logic          Reset,
  mult_control_if.master bus
);
  localparam int CNT_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_ADD   = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic ld_b, clear_xa, ld_a, add, sub, shift_en, busy, done;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    ld_b     = 1'b0;
    clear_xa = 1'b0;
    ld_a     = 1'b0;
    add      = 1'b0;
    sub      = 1'b0;
    shift_en = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.Run) begin
          state_d = S_START;
        end else if (bus.ClearA_LoadB) begin
          ld_b     = 1'b1;
          clear_xa = 1'b1;
        end
      end
      S_START: begin
        busy     = 1'b1;
        clear_xa = 1'b1;
        count_d  = '0;
        state_d  = S_ADD;
      end
      S_ADD: begin
        busy    = 1'b1;
        state_d = S_SHIFT;
        // Final partial product carries the sign weight, so it is subtracted
        if (bus.M) begin
          ld_a = 1'b1;
          if (count_q == CNT_LAST) begin
            sub = 1'b1;
          end else begin
            add = 1'b1;
          end
        end
      end
      S_SHIFT: begin
        busy     = 1'b1;
        shift_en = 1'b1;
        if (count_q == CNT_LAST) begin
          state_d = S_DONE;
        end else begin
          count_d = count_q + 1'b1;
          state_d = S_ADD;
        end
      end
      S_DONE: begin
        done = 1'b1;
        if (!bus.Run) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Mealy terms would otherwise leak through while Reset is held
  assign bus.Ld_B     = ld_b     & ~Reset;
  assign bus.Clear_XA = clear_xa & ~Reset;
  assign bus.Ld_A     = ld_a     & ~Reset;
  assign bus.Add      = add      & ~Reset;
  assign bus.Sub      = sub      & ~Reset;
  assign bus.Shift_En = shift_en & ~Reset;
  assign bus.Busy     = busy     & ~Reset;
  assign bus.Done     = done     & ~Reset;
  assign bus.Count    = Reset ? '0 : count_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_control.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mult_control : directed self-checking bench for mult_control          |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_mult_control;
  logic       Clk;
  logic       Reset;
  logic [7:0] b_q = 8'h00;
  logic [7:0] b_init;
  logic       b_load;
  logic       m_sel;
  logic       m_ovr;
  int         n_checks = 0;
  int         n_errors = 0;

  mult_control_if #(.N_BITS(8)) bus ();

  mult_control #(.N_BITS(8)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Minimal B register model: supplies M = B[0], shifts on Shift_En
  always @(posedge Clk) begin
    if (b_load) b_q <= b_init;
    else if (bus.Shift_En) b_q <= b_q >> 1;
  end
  assign bus.M = m_sel ? m_ovr : b_q[0];

  wire [10:0] outs = {bus.Ld_B, bus.Clear_XA, bus.Ld_A, bus.Add, bus.Sub,
                      bus.Shift_En, bus.Busy, bus.Done, bus.Count};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic run_mult(input logic [7:0] b, input logic [7:0] exp_add,
                          input logic [7:0] exp_sub, input bit hold_run);
    logic [7:0] add_mask, sub_mask, lda_mask;
    int shifts, clears, both, done_early;
    add_mask = '0; sub_mask = '0; lda_mask = '0;
    shifts = 0; clears = 0; both = 0; done_early = 0;
    @(negedge Clk);
    bus.Run = 1'b1; b_init = b; b_load = 1'b1;
    @(negedge Clk);
    b_load = 1'b0;
    if (!hold_run) bus.Run = 1'b0;
    check("start_clear_xa", 32'(bus.Clear_XA), 32'd1);
    check("start_busy", 32'(bus.Busy), 32'd1);
    for (int k = 1; k <= 16; k++) begin
      @(negedge Clk);
      if (bus.Add)      add_mask[bus.Count] = 1'b1;
      if (bus.Sub)      sub_mask[bus.Count] = 1'b1;
      if (bus.Ld_A)     lda_mask[bus.Count] = 1'b1;
      if (bus.Shift_En) shifts++;
      if (bus.Clear_XA) clears++;
      if (bus.Add && bus.Sub) both++;
      if (bus.Done || !bus.Busy) done_early++;
    end
    check("add_iters", 32'(add_mask), 32'(exp_add));
    check("sub_iters", 32'(sub_mask), 32'(exp_sub));
    check("lda_iters", 32'(lda_mask), 32'(exp_add | exp_sub));
    check("shift_pulses", 32'(shifts), 32'd8);
    check("extra_clear_xa", 32'(clears), 32'd0);
    check("add_and_sub", 32'(both), 32'd0);
    check("busy_window", 32'(done_early), 32'd0);
    @(negedge Clk);
    check("done_edge17", 32'(bus.Done), 32'd1);
    check("done_busy", 32'(bus.Busy), 32'd0);
    check("done_count", 32'(bus.Count), 32'd7);
    if (!hold_run) begin
      @(negedge Clk);
      check("back_idle", 32'(bus.Done), 32'd0);
    end
  endtask

  initial begin
    bit found;
    Reset = 1'b1; bus.Run = 1'b0; bus.ClearA_LoadB = 1'b0;
    b_init = '0; b_load = 1'b0; m_sel = 1'b1; m_ovr = 1'b0;

    // Reset held while inputs toggle
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk);
      bus.Run = i[0]; bus.ClearA_LoadB = i[1]; m_ovr = i[2] ^ i[0];
      #1 check("reset_outs", 32'(outs), 32'd0);
    end
    @(negedge Clk);
    Reset = 1'b0; bus.Run = 1'b0; bus.ClearA_LoadB = 1'b0; m_sel = 1'b0;
    #1 check("release_outs", 32'(outs), 32'd0);
    @(negedge Clk);
    check("idle_outs", 32'(outs), 32'd0);

    // ClearA_LoadB in IDLE
    for (int i = 0; i < 3; i++) begin
      bus.ClearA_LoadB = 1'b1;
      #1;
      check("clr_ld_b", 32'(bus.Ld_B), 32'd1);
      check("clr_clear_xa", 32'(bus.Clear_XA), 32'd1);
      check("clr_busy", 32'(bus.Busy), 32'd0);
      @(negedge Clk);
    end
    bus.ClearA_LoadB = 1'b0;
    #1 check("clr_off", 32'({bus.Ld_B, bus.Clear_XA}), 32'd0);

    run_mult(8'h07, 8'h07, 8'h00, 1'b0);
    run_mult(8'h80, 8'h00, 8'h80, 1'b0);

    // Run held past Done
    run_mult(8'h07, 8'h07, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      check("hold_done", 32'(bus.Done), 32'd1);
      check("hold_no_clear", 32'(bus.Clear_XA), 32'd0);
    end
    bus.Run = 1'b0;
    @(negedge Clk);
    check("release_idle", 32'({bus.Done, bus.Busy}), 32'd0);
    bus.Run = 1'b1; bus.ClearA_LoadB = 1'b1; b_init = 8'hFF; b_load = 1'b1;
    #1 check("run_prio_ld_b", 32'({bus.Ld_B, bus.Clear_XA}), 32'd0);
    @(negedge Clk);
    b_load = 1'b0; bus.Run = 1'b0; bus.ClearA_LoadB = 1'b0;
    check("prio_start", 32'({bus.Clear_XA, bus.Busy}), 32'h3);

    // Reset mid-operation at Count=4 in ADD
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      if (bus.Busy && !bus.Shift_En && bus.Count == 3'd4) begin
        found = 1'b1;
        break;
      end
    end
    check("reach_add4", 32'(found), 32'd1);
    check("add4_strobes", 32'({bus.Add, bus.Ld_A}), 32'h3);
    #2 Reset = 1'b1;
    #1 check("async_drop", 32'(outs), 32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    #1 check("post_rst_outs", 32'(outs), 32'd0);
    @(negedge Clk);
    check("post_rst_idle", 32'(outs), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
`default_nettype wire
